// File: rtl/bus_slave_resp_mux_if.sv
// Bus bundle between the slave ports and the master-side response of the mux.
interface bus_slave_resp_mux_if #(
   parameter int unsigned NUM_SLAVES = 8,
   parameter int unsigned DATA_W     = 32
);
   logic [NUM_SLAVES-1:0]        s_cs_;
   logic [NUM_SLAVES*DATA_W-1:0] s_rd_data;
   logic [NUM_SLAVES-1:0]        s_rdy_;
   logic [DATA_W-1:0]            m_rd_data;
   logic                         m_rdy_;
   logic                         m_err;
   logic                         multi_sel;

   // Mux side: consumes slave signals, produces the master response.
   modport slave (
      input  s_cs_, s_rd_data, s_rdy_,
      output m_rd_data, m_rdy_, m_err, multi_sel
   );

   // Environment side: drives slave signals, observes the master response.
   modport master (
      output s_cs_, s_rd_data, s_rdy_,
      input  m_rd_data, m_rdy_, m_err, multi_sel
   );
endinterface

// File: rtl/bus_slave_resp_mux.sv
// Registered bus slave response multiplexer with access FSM, timeout error
// response and sticky multi-select detection.
module bus_slave_resp_mux #(
   parameter int unsigned NUM_SLAVES = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                reset,
   bus_slave_resp_mux_if.slave bus
);
   localparam int unsigned SEL_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                err_q, err_d;
   logic                rdy_n_q, rdy_n_d;
   logic                multi_q, multi_d;

   logic [NUM_SLAVES-1:0] cs_low;
   logic                  any_cs;
   logic                  multi_now;
   logic [SEL_W-1:0]      sel_now;
   logic [SEL_W-1:0]      mux_sel;
   logic                  cs_sel;
   logic                  rdy_sel;
   logic [DATA_W-1:0]     mux_data;

   // Decode active selects: lowest asserted index wins, flag more than one.
   always_comb begin
      cs_low    = ~bus.s_cs_;
      any_cs    = |cs_low;
      multi_now = |(cs_low & (cs_low - NUM_SLAVES'(1)));
      sel_now   = '0;
      for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
         if (cs_low[i]) sel_now = SEL_W'(i);
      end
   end

   // Route the selected slave: fresh decode in IDLE, latched index afterwards.
   always_comb begin
      mux_sel  = (state_q == IDLE) ? sel_now : sel_q;
      cs_sel   = 1'b0;
      rdy_sel  = 1'b0;
      mux_data = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (SEL_W'(i) == mux_sel) begin
            cs_sel   = cs_low[i];
            rdy_sel  = ~bus.s_rdy_[i];
            mux_data = bus.s_rd_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Access FSM next state and response capture.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (any_cs) begin
               sel_d = sel_now;
               if (rdy_sel) begin
                  rd_data_d = mux_data;
                  err_d     = 1'b0;
                  state_d   = DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (!cs_sel) begin
               state_d = IDLE;
            end else if (rdy_sel) begin
               rd_data_d = mux_data;
               err_d     = 1'b0;
               state_d   = DONE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
               rd_data_d = '0;
               err_d     = 1'b1;
               state_d   = DONE;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // Turnaround cycle: all slave inputs ignored.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rdy_n_d = (state_d != DONE);
      multi_d = multi_q | ((state_q != DONE) & multi_now);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
         rdy_n_q   <= 1'b1;
         multi_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
         rdy_n_q   <= rdy_n_d;
         multi_q   <= multi_d;
      end
   end

   assign bus.m_rd_data = rd_data_q;
   assign bus.m_rdy_    = rdy_n_q;
   assign bus.m_err     = err_q;
   assign bus.multi_sel = multi_q;

endmodule

// File: tb/tb_bus_slave_resp_mux.sv
// Directed self-checking bench for bus_slave_resp_mux across four parameter sets.
module tb_bus_slave_resp_mux;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   pulses;

   bus_slave_resp_mux_if #(.NUM_SLAVES(8),  .DATA_W(32)) bus0 ();
   bus_slave_resp_mux_if #(.NUM_SLAVES(8),  .DATA_W(32)) bus1 ();
   bus_slave_resp_mux_if #(.NUM_SLAVES(1),  .DATA_W(8))  bus2 ();
   bus_slave_resp_mux_if #(.NUM_SLAVES(32), .DATA_W(64)) bus3 ();

   bus_slave_resp_mux #(.NUM_SLAVES(8),  .DATA_W(32), .TIMEOUT(64)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   bus_slave_resp_mux #(.NUM_SLAVES(8),  .DATA_W(32), .TIMEOUT(0))  dut1 (.clk(clk), .reset(reset), .bus(bus1));
   bus_slave_resp_mux #(.NUM_SLAVES(1),  .DATA_W(8),  .TIMEOUT(4))  dut2 (.clk(clk), .reset(reset), .bus(bus2));
   bus_slave_resp_mux #(.NUM_SLAVES(32), .DATA_W(64), .TIMEOUT(4))  dut3 (.clk(clk), .reset(reset), .bus(bus3));

   // The TIMEOUT=0 instance sees exactly the same slave traffic as dut0.
   assign bus1.s_cs_     = bus0.s_cs_;
   assign bus1.s_rdy_    = bus0.s_rdy_;
   assign bus1.s_rd_data = bus0.s_rd_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs and samples happen here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus0.s_cs_ = '1; bus0.s_rdy_ = '1; bus0.s_rd_data = '0;
      bus2.s_cs_ = '1; bus2.s_rdy_ = '1; bus2.s_rd_data = '0;
      bus3.s_cs_ = '1; bus3.s_rdy_ = '1; bus3.s_rd_data = '0;
   endtask

   task automatic release0();
      bus0.s_cs_ = '1; bus0.s_rdy_ = '1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      pulses = 0;
      reset  = 1'b1;
      idle_all();
      repeat (3) step();

      // Reset state on every instance.
      chk("rst_rdy0",   64'(bus0.m_rdy_),     64'd1);
      chk("rst_data0",  64'(bus0.m_rd_data),  64'd0);
      chk("rst_err0",   64'(bus0.m_err),      64'd0);
      chk("rst_multi0", 64'(bus0.multi_sel),  64'd0);
      chk("rst_rdy1",   64'(bus1.m_rdy_),     64'd1);
      chk("rst_rdy2",   64'(bus2.m_rdy_),     64'd1);
      chk("rst_rdy3",   64'(bus3.m_rdy_),     64'd1);
      reset = 1'b0;
      step();

      // Immediate read on slave 3.
      bus0.s_cs_[3] = 1'b0; bus0.s_rdy_[3] = 1'b0;
      bus0.s_rd_data[3*32 +: 32] = 32'hCAFEF00D;
      step();
      chk("imm_rdy",   64'(bus0.m_rdy_),    64'd0);
      chk("imm_data",  64'(bus0.m_rd_data), 64'hCAFEF00D);
      chk("imm_err",   64'(bus0.m_err),     64'd0);
      chk("imm_rdy_t0", 64'(bus1.m_rdy_),   64'd0);
      release0();
      step();
      chk("imm_rdy_c2",  64'(bus0.m_rdy_),    64'd1);
      chk("imm_hold_c2", 64'(bus0.m_rd_data), 64'hCAFEF00D);

      // Wait states: slave 5 ready in cycle 4.
      bus0.s_cs_[5] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("ws_rdy_c%0d", c), 64'(bus0.m_rdy_), 64'd1);
         if (c == 4) begin
            bus0.s_rdy_[5] = 1'b0;
            bus0.s_rd_data[5*32 +: 32] = 32'h12345678;
         end
      end
      step();
      chk("ws_rdy_c5",  64'(bus0.m_rdy_),    64'd0);
      chk("ws_data_c5", 64'(bus0.m_rd_data), 64'h12345678);
      release0();
      step();
      chk("ws_rdy_c6",  64'(bus0.m_rdy_),    64'd1);

      // Ready in cycle TIMEOUT beats the timeout.
      bus0.s_cs_[5] = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 64; c++) begin
         step();
         if (!bus0.m_rdy_) pulses++;
         if (c == 64) begin
            bus0.s_rdy_[5] = 1'b0;
            bus0.s_rd_data[5*32 +: 32] = 32'h0BADBEEF;
         end
      end
      chk("late_nopulse", 64'(pulses), 64'd0);
      step();
      chk("late_rdy_c65",  64'(bus0.m_rdy_),    64'd0);
      chk("late_err_c65",  64'(bus0.m_err),     64'd0);
      chk("late_data_c65", 64'(bus0.m_rd_data), 64'h0BADBEEF);
      release0();
      step();

      // Timeout on slave 1 with no ready.
      bus0.s_cs_[1] = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 64; c++) begin
         step();
         if (!bus0.m_rdy_) pulses++;
      end
      chk("to_nopulse", 64'(pulses), 64'd0);
      step();
      chk("to_rdy_c65",  64'(bus0.m_rdy_),    64'd0);
      chk("to_err_c65",  64'(bus0.m_err),     64'd1);
      chk("to_data_c65", 64'(bus0.m_rd_data), 64'd0);
      release0();
      step();
      chk("to_rdy_c66",  64'(bus0.m_rdy_), 64'd1);
      chk("to_err_hold", 64'(bus0.m_err),  64'd1);

      // TIMEOUT=0 instance must never respond while select is held.
      bus0.s_cs_[1] = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 1000; c++) begin
         step();
         if (!bus1.m_rdy_) pulses++;
      end
      chk("notimeout_pulses", 64'(pulses), 64'd0);
      release0();
      repeat (3) step();

      // Multi-select: slaves 2 and 6, lowest wins.
      chk("multi_pre", 64'(bus0.multi_sel), 64'd0);
      bus0.s_cs_[2] = 1'b0; bus0.s_cs_[6] = 1'b0;
      bus0.s_rdy_[2] = 1'b0; bus0.s_rdy_[6] = 1'b0;
      bus0.s_rd_data[2*32 +: 32] = 32'hAAAA0002;
      bus0.s_rd_data[6*32 +: 32] = 32'hBBBB0006;
      step();
      chk("multi_rdy",  64'(bus0.m_rdy_),    64'd0);
      chk("multi_data", 64'(bus0.m_rd_data), 64'hAAAA0002);
      chk("multi_flag", 64'(bus0.multi_sel), 64'd1);
      release0();
      step();
      bus0.s_cs_[4] = 1'b0; bus0.s_rdy_[4] = 1'b0;
      bus0.s_rd_data[4*32 +: 32] = 32'h00000044;
      step();
      chk("clean_data",   64'(bus0.m_rd_data), 64'h00000044);
      chk("multi_sticky", 64'(bus0.multi_sel), 64'd1);
      release0();
      step();

      // Abort: slave 0 released in BUSY cycle 3, new select in cycle 4.
      bus0.s_cs_[0] = 1'b0;
      step(); step(); step();
      bus0.s_cs_[0] = 1'b1;
      step();
      chk("abort_nopulse", 64'(bus0.m_rdy_), 64'd1);
      bus0.s_cs_[7] = 1'b0; bus0.s_rdy_[7] = 1'b0;
      bus0.s_rd_data[7*32 +: 32] = 32'h77770007;
      step();
      chk("abort_new_rdy",  64'(bus0.m_rdy_),    64'd0);
      chk("abort_new_data", 64'(bus0.m_rd_data), 64'h77770007);
      release0();
      step();

      // Reset while BUSY, with a ready arriving on the same edge.
      bus0.s_cs_[2] = 1'b0;
      step(); step();
      bus0.s_rdy_[2] = 1'b0;
      bus0.s_rd_data[2*32 +: 32] = 32'h55555555;
      reset = 1'b1;
      step();
      chk("rstb_rdy",   64'(bus0.m_rdy_),    64'd1);
      chk("rstb_data",  64'(bus0.m_rd_data), 64'd0);
      chk("rstb_err",   64'(bus0.m_err),     64'd0);
      chk("rstb_multi", 64'(bus0.multi_sel), 64'd0);
      reset = 1'b0;
      release0();
      pulses = 0;
      repeat (3) begin
         step();
         if (!bus0.m_rdy_) pulses++;
      end
      chk("rstb_nopulse", 64'(pulses), 64'd0);

      // Parameter corners: immediate read on slave 0 / slave 31.
      bus2.s_cs_[0] = 1'b0; bus2.s_rdy_[0] = 1'b0; bus2.s_rd_data = 8'hA5;
      bus3.s_cs_[31] = 1'b0; bus3.s_rdy_[31] = 1'b0;
      bus3.s_rd_data[31*64 +: 64] = 64'hDEADBEEF01234567;
      step();
      chk("p1_imm_rdy",  64'(bus2.m_rdy_),    64'd0);
      chk("p1_imm_data", 64'(bus2.m_rd_data), 64'hA5);
      chk("p32_imm_rdy", 64'(bus3.m_rdy_),    64'd0);
      chk("p32_imm_data", 64'(bus3.m_rd_data), 64'hDEADBEEF01234567);
      bus2.s_cs_ = '1; bus2.s_rdy_ = '1;
      bus3.s_cs_ = '1; bus3.s_rdy_ = '1;
      step();

      // Parameter corners: timeout (TIMEOUT=4) on slave 0 / slave 31.
      bus2.s_cs_[0] = 1'b0;
      bus3.s_cs_[31] = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (!bus2.m_rdy_) pulses++;
         if (!bus3.m_rdy_) pulses++;
      end
      chk("p_to_nopulse", 64'(pulses), 64'd0);
      step();
      chk("p1_to_rdy",   64'(bus2.m_rdy_),    64'd0);
      chk("p1_to_err",   64'(bus2.m_err),     64'd1);
      chk("p1_to_data",  64'(bus2.m_rd_data), 64'd0);
      chk("p32_to_rdy",  64'(bus3.m_rdy_),    64'd0);
      chk("p32_to_err",  64'(bus3.m_err),     64'd1);
      chk("p32_to_data", 64'(bus3.m_rd_data), 64'd0);
      bus2.s_cs_ = '1;
      bus3.s_cs_ = '1;
      step();
      chk("p1_to_after",  64'(bus2.m_rdy_), 64'd1);
      chk("p32_to_after", 64'(bus3.m_rdy_), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
